// File: rtl/la_crc_pkg.sv
// Shared definitions for the serial CRC blocks: FSM encoding and standard
// polynomial presets, each given as poly/init/xorout.
package la_crc_pkg;

  typedef enum logic {
    DATA   = 1'b0,
    APPEND = 1'b1
  } state_e;

  localparam logic [31:0] CRC8_SMBUS_POLY    = 32'h0000_0007;
  localparam logic [31:0] CRC8_SMBUS_INIT    = 32'h0000_0000;
  localparam logic [31:0] CRC8_SMBUS_XOROUT  = 32'h0000_0000;

  localparam logic [31:0] CRC16_CCITT_POLY   = 32'h0000_1021;
  localparam logic [31:0] CRC16_CCITT_INIT   = 32'h0000_FFFF;
  localparam logic [31:0] CRC16_CCITT_XOROUT = 32'h0000_0000;

  localparam logic [31:0] CRC32_POLY         = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT       = 32'hFFFF_FFFF;

endpackage

// File: rtl/la_crcstep.sv
// Combinational single-bit Galois LFSR update: XOR cells only where POLY has taps.
module la_crcstep #(
  parameter int          WIDTH = 8,
  parameter logic [31:0] POLY  = 32'h07,
  parameter string       PROP  = "DEFAULT"
) (
  input  logic [WIDTH-1:0] crc_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] crc_o
);

  logic fb;

  la_xor2 #(.PROP(PROP)) u_fb (
    .a_i(crc_i[WIDTH-1]),
    .b_i(bit_i),
    .y_o(fb)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_tap
    logic shifted;

    if (i == 0) begin : g_lsb
      assign shifted = 1'b0;
    end else begin : g_shift
      assign shifted = crc_i[i-1];
    end

    if (POLY[i]) begin : g_xor
      la_xor2 #(.PROP(PROP)) u_x (
        .a_i(shifted),
        .b_i(fb),
        .y_o(crc_o[i])
      );
    end else begin : g_pass
      assign crc_o[i] = shifted;
    end
  end

endmodule

// File: rtl/la_xor2.sv
// Two-input XOR cell used at the LFSR taps; PROP selects the gate-level form.
module la_xor2 #(
  parameter string PROP = "DEFAULT"
) (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  // "NAND" builds the classic four-NAND XOR for flows that want plain gates.
  if (PROP == "NAND") begin : g_nand
    logic n;
    assign n   = ~(a_i & b_i);
    assign y_o = ~(~(a_i & n) & ~(b_i & n));
  end else begin : g_xor
    assign y_o = a_i ^ b_i;
  end

endmodule

// File: rtl/la_crcser.sv
// Serial CRC generator: forwards payload bits through one output register and
// appends the WIDTH-bit CRC, MSB first, after the bit flagged in_last.
module la_crcser
  import la_crc_pkg::*;
#(
  parameter int          WIDTH  = 8,
  parameter logic [31:0] POLY   = CRC8_SMBUS_POLY,
  parameter logic [31:0] INIT   = CRC8_SMBUS_INIT,
  parameter logic [31:0] XOROUT = CRC8_SMBUS_XOROUT,
  parameter string       PROP   = "DEFAULT"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] crc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] XOROUT_W = XOROUT[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             od_q, od_d;
  logic             ol_q, ol_d;
  logic             slot_free;
  logic             accept;

  la_crcstep #(.WIDTH(WIDTH), .POLY(POLY), .PROP(PROP)) u_step (
    .crc_i(crc_q),
    .bit_i(in_data),
    .crc_o(step)
  );

  // The output register may be reloaded whenever it is empty or being drained.
  assign slot_free = !ov_q | out_ready;
  assign in_ready  = (state_q == DATA) & slot_free;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= DATA;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DATA:    if (accept && in_last)            state_d = APPEND;
      APPEND:  if (slot_free && cnt_q == '0)     state_d = DATA;
      default:                                   state_d = DATA;
    endcase
  end

  always_comb begin
    crc_d  = crc_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    ov_d   = ov_q;
    od_d   = od_q;
    ol_d   = ol_q;
    case (state_q)
      DATA: begin
        if (accept) begin
          od_d  = in_data;
          ov_d  = 1'b1;
          ol_d  = 1'b0;
          crc_d = step;
          if (in_last) begin
            sreg_d = step ^ XOROUT_W;
            cnt_d  = CW'(WIDTH - 1);
          end
        end else if (slot_free) begin
          ov_d = 1'b0;
        end
      end
      APPEND: begin
        if (slot_free) begin
          od_d   = sreg_q[WIDTH-1];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          ov_d   = 1'b1;
          ol_d   = (cnt_q == '0);
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == '0) crc_d = INIT_W;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q  <= INIT_W;
      sreg_q <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
      od_q   <= 1'b0;
      ol_q   <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      ol_q   <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign crc       = crc_q;

endmodule

// File: tb/tb_la_crcser.sv
// Self-checking bench for la_crcser: scoreboard of expected output bits for the
// CRC-8 instance plus a CRC-16/CCITT instance checked on the standard vector.
module tb_la_crcser;
  import la_crc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_data, in_last, in_ready;
  logic       out_valid, out_data, out_last;
  logic       out_ready = 1'b1;
  logic [7:0] crc;

  logic        in_valid16, in_data16, in_last16, in_ready16;
  logic        out_valid16, out_data16, out_last16;
  logic        out_ready16 = 1'b1;
  logic [15:0] crc16;

  int checkCount = 0;
  int errorCount = 0;

  logic [1:0]  expQ[$];
  logic [1:0]  expBits;
  logic [7:0]  crcLog[$];
  logic [7:0]  rxShift = 8'h00;
  logic [7:0]  lastCrc = 8'h00;
  logic        stallPending = 1'b0;
  logic        holdData, holdLast;
  int          cycleNo = 0;
  int          firstXfer = -1;
  int          lastXfer = 0;

  logic [15:0] rx16 = 16'h0000;
  logic [15:0] lastCrc16 = 16'h0000;
  int          count16 = 0;

  bit          gapMode = 1'b0;
  bit          stallMode = 1'b0;
  logic [71:0] ascii;

  always #5 clk = ~clk;

  la_crcser dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .crc(crc)
  );

  la_crcser #(
    .WIDTH(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_CCITT_INIT), .XOROUT(CRC16_CCITT_XOROUT)
  ) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_data(in_data16), .in_last(in_last16), .in_ready(in_ready16),
    .out_valid(out_valid16), .out_data(out_data16), .out_last(out_last16), .out_ready(out_ready16),
    .crc(crc16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0, no xorout), bits taken MSB first.
  function automatic logic [7:0] crc8Model(input logic [71:0] bits, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    cycleNo++;
    if (reset) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, holdData);
        checkOutput("hold_last", out_last, holdLast);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_empty", out_valid, 0);
        end else begin
          expBits = expQ.pop_front();
          checkOutput("out_data", out_data, expBits[1]);
          checkOutput("out_last", out_last, expBits[0]);
        end
        rxShift = {rxShift[6:0], out_data};
        if (firstXfer < 0) firstXfer = cycleNo;
        if (out_last) begin
          lastCrc  = rxShift;
          lastXfer = cycleNo;
          crcLog.push_back(rxShift);
          checkOutput("crc_init_after_frame", crc, 0);
        end
      end
      stallPending = out_valid && !out_ready;
      holdData     = out_data;
      holdLast     = out_last;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid16 && out_ready16) begin
      rx16 = {rx16[14:0], out_data16};
      count16++;
      if (out_last16) lastCrc16 = rx16;
    end
  end

  task automatic driveBit(input logic d, input logic last);
    int   waited = 0;
    logic acc;
    if (gapMode) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) checkOutput("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [71:0] bits, input int n);
    logic [7:0] c;
    c = crc8Model(bits, n);
    for (int i = n - 1; i >= 0; i--) expQ.push_back({bits[i], 1'b0});
    for (int i = 7; i >= 0; i--) expQ.push_back({c[i], (i == 0) ? 1'b1 : 1'b0});
    for (int i = n - 1; i >= 0; i--) driveBit(bits[i], (i == 0) ? 1'b1 : 1'b0);
  endtask

  task automatic waitDrain();
    int k = 0;
    while ((expQ.size() != 0 || out_valid) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_left", expQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    errorCount++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ascii      = "123456789";
    reset      = 1'b1;
    in_valid   = 1'b0; in_data   = 1'b0; in_last   = 1'b0;
    in_valid16 = 1'b0; in_data16 = 1'b0; in_last16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_crc", crc, 32'h00);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_crc16", crc16, 32'hFFFF);
    reset = 1'b0;

    applyStimulus(72'h80, 8);
    waitDrain();
    checkOutput("crc_0x80", lastCrc, 32'h89);

    applyStimulus(ascii, 72);
    waitDrain();
    checkOutput("crc_ascii", lastCrc, 32'hF4);

    // Same vector with random gaps and backpressure must give the same bitstream.
    stallMode = 1'b1;
    gapMode   = 1'b1;
    applyStimulus(ascii, 72);
    waitDrain();
    checkOutput("crc_ascii_stall", lastCrc, 32'hF4);
    stallMode = 1'b0;
    gapMode   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    crcLog.delete();
    firstXfer = -1;
    applyStimulus(72'h01, 8);
    applyStimulus(72'h00, 8);
    waitDrain();
    checkOutput("b2b_frames", crcLog.size(), 2);
    if (crcLog.size() >= 2) begin
      checkOutput("b2b_crc_first", crcLog[0], 32'h07);
      checkOutput("b2b_crc_second", crcLog[1], 32'h00);
    end
    checkOutput("b2b_span", lastXfer - firstXfer, 31);

    // Reset in the middle of the appended CRC drops the rest of the frame.
    applyStimulus(72'h80, 8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_crc", crc, 32'h00);
    checkOutput("midreset_in_ready", in_ready, 1);
    applyStimulus(72'h80, 8);
    waitDrain();
    checkOutput("crc_after_reset", lastCrc, 32'h89);

    // One-bit frame, then in_last held high while the CRC is being appended.
    applyStimulus(72'h1, 1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 1'b1;
    repeat (7) begin
      @(negedge clk);
      checkOutput("append_in_ready", in_ready, 0);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDrain();
    checkOutput("crc_one_bit", lastCrc, 32'h07);

    for (int i = 71; i >= 0; i--) begin
      in_valid16 = 1'b1;
      in_data16  = ascii[i];
      in_last16  = (i == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      checkOutput("in_ready16", in_ready16, 1);
      @(posedge clk);
      #1;
    end
    in_valid16 = 1'b0;
    in_last16  = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    checkOutput("crc16_ascii", lastCrc16, 32'h29B1);
    checkOutput("crc16_bit_count", count16, 88);
    checkOutput("crc16_init_after", crc16, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
